// File: rtl/bno085_report_parser_pkg.sv
// Shared types and constants for the BNO085 SHTP report parser.
//   - parse_state_e : parser FSM states
//   - rpt_kind_e    : report currently being walked (timestamp, rotation, gyro)
//   - SHTP header size, report IDs and report lengths (all including the ID byte)
//   - rpt_last_idx(): byte offset of the final byte of a report
package bno085_report_parser_pkg;

    localparam logic [7:0]  DefSensorChannel = 8'd3;
    localparam logic [7:0]  DefRotReportId   = 8'h08;
    localparam logic [7:0]  DefGyroReportId  = 8'h02;
    localparam logic [7:0]  TsBaseId         = 8'hFB;
    localparam logic [7:0]  TsDeltaId        = 8'hFA;

    localparam int unsigned ShtpHdrBytes     = 4;
    localparam int unsigned RotReportLen     = 12;
    localparam int unsigned GyroReportLen    = 10;
    localparam int unsigned TsReportLen      = 5;

    typedef enum logic [2:0] {
        StIdle,
        StHdr,
        StRptId,
        StRptBody,
        StDiscard
    } parse_state_e;

    typedef enum logic [1:0] {
        RptTs,
        RptRot,
        RptGyro
    } rpt_kind_e;

    function automatic logic [3:0] rpt_last_idx(rpt_kind_e kind);
        case (kind)
            RptRot:  return 4'(RotReportLen - 1);
            RptGyro: return 4'(GyroReportLen - 1);
            default: return 4'(TsReportLen - 1);
        endcase
    endfunction

endpackage

// File: rtl/bno085_report_parser_if.sv
// Byte-stream in / decoded reports out for the BNO085 report parser.
//   master : byte source side (drives rx_*, observes results)
//   slave  : parser side (consumes rx_*, drives quat_*, gyro_*, parse_err)
//   rx_frame_start/rx_frame_end : CS assert/release pulses
//   rx_valid/rx_byte            : one received byte per asserted cycle
//   quat_valid + quat_w/x/y/z   : rotation vector (Q14), one-cycle valid pulse
//   gyro_valid + gyro_x/y/z     : calibrated gyro (Q9), one-cycle valid pulse
//   parse_err                   : one-cycle pulse when a packet/report is dropped
interface bno085_report_parser_if;

    logic               rx_frame_start;
    logic               rx_frame_end;
    logic               rx_valid;
    logic [7:0]         rx_byte;

    logic               quat_valid;
    logic signed [15:0] quat_w;
    logic signed [15:0] quat_x;
    logic signed [15:0] quat_y;
    logic signed [15:0] quat_z;
    logic               gyro_valid;
    logic signed [15:0] gyro_x;
    logic signed [15:0] gyro_y;
    logic signed [15:0] gyro_z;
    logic               parse_err;

    modport master (
        output rx_frame_start, rx_frame_end, rx_valid, rx_byte,
        input  quat_valid, quat_w, quat_x, quat_y, quat_z,
        input  gyro_valid, gyro_x, gyro_y, gyro_z, parse_err
    );

    modport slave (
        input  rx_frame_start, rx_frame_end, rx_valid, rx_byte,
        output quat_valid, quat_w, quat_x, quat_y, quat_z,
        output gyro_valid, gyro_x, gyro_y, gyro_z, parse_err
    );

endinterface

// File: rtl/bno085_report_parser_shtp_header_decoder.sv
// Captures the 4-byte SHTP header (lenL, lenH, channel, seq) and tracks how many
// payload bytes remain in the packet.
//   clk, rst    : clock, synchronous active-high reset
//   start       : frame start; resets the header walk (a coincident valid byte is lenL)
//   byte_valid  : rx_valid, only consulted together with start
//   hdr_valid   : a header byte is being accepted this cycle
//   rx_byte     : received byte
//   pay_dec     : a payload byte is being accepted this cycle
//   length      : 15-bit packet length including header (continuation bit dropped)
//   channel     : SHTP channel number
//   remaining   : payload bytes still expected (0 when length < 4)
//   hdr_last    : next accepted header byte is the final one (seq)
module bno085_report_parser_shtp_header_decoder
    import bno085_report_parser_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        byte_valid,
    input  logic        hdr_valid,
    input  logic [7:0]  rx_byte,
    input  logic        pay_dec,
    output logic [14:0] length,
    output logic [7:0]  channel,
    output logic [14:0] remaining,
    output logic        hdr_last
);

    logic [1:0]  idx_q;
    logic [7:0]  len_l_q;
    logic [6:0]  len_h_q;
    logic [7:0]  chan_q;
    logic [14:0] rem_q;

    assign length    = {len_h_q, len_l_q};
    assign channel   = chan_q;
    assign remaining = rem_q;
    assign hdr_last  = (idx_q == 2'd3);

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q   <= '0;
            len_l_q <= '0;
            len_h_q <= '0;
            chan_q  <= '0;
            rem_q   <= '0;
        end else if (start) begin
            rem_q <= '0;
            if (byte_valid) begin
                len_l_q <= rx_byte;
                idx_q   <= 2'd1;
            end else begin
                idx_q   <= 2'd0;
            end
        end else if (hdr_valid) begin
            case (idx_q)
                2'd0:    len_l_q <= rx_byte;
                2'd1:    len_h_q <= rx_byte[6:0];
                2'd2:    chan_q  <= rx_byte;
                // Sequence byte carries nothing we use; length is complete by now.
                default: rem_q   <= (length >= 15'(ShtpHdrBytes)) ?
                                    length - 15'(ShtpHdrBytes) : '0;
            endcase
            idx_q <= idx_q + 2'd1;
        end else if (pay_dec && rem_q != '0) begin
            rem_q <= rem_q - 15'd1;
        end
    end

endmodule

// File: rtl/bno085_report_parser.sv
// SHTP byte-stream parser for the BNO085. Walks channel-SensorChannel packets report by
// report, assembles game-rotation-vector and calibrated-gyro reports into shadow
// registers and commits them to the outputs with a one-cycle valid pulse.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of bno085_report_parser_if (byte stream in, reports out)
module bno085_report_parser
    import bno085_report_parser_pkg::*;
#(
    parameter logic [7:0] SensorChannel = DefSensorChannel,
    parameter logic [7:0] RotReportId   = DefRotReportId,
    parameter logic [7:0] GyroReportId  = DefGyroReportId
) (
    input  logic                    clk,
    input  logic                    rst,
    bno085_report_parser_if.slave   bus
);

    parse_state_e state_q, state_d;
    rpt_kind_e    kind_q, kind_d;
    logic [3:0]   idx_q, idx_d;        // byte offset within current report (ID = 0)
    logic [15:0]  sh_q [4];            // shadow words for report offsets 4..11
    logic [1:0]   sh_sel;

    logic         hdr_valid;
    logic         pay_byte;
    logic         sh_we;
    logic         id_known;
    logic         err_d;
    logic         commit_rot;
    logic         commit_gyro;

    logic [14:0]  length;
    logic [7:0]   channel;
    logic [14:0]  remaining;
    logic         hdr_last;
    logic         pay_last;

    logic         quat_valid_q, gyro_valid_q, parse_err_q;
    logic [15:0]  quat_w_q, quat_x_q, quat_y_q, quat_z_q;
    logic [15:0]  gyro_x_q, gyro_y_q, gyro_z_q;

    bno085_report_parser_shtp_header_decoder u_hdr (
        .clk        (clk),
        .rst        (rst),
        .start      (bus.rx_frame_start),
        .byte_valid (bus.rx_valid),
        .hdr_valid  (hdr_valid),
        .rx_byte    (bus.rx_byte),
        .pay_dec    (pay_byte),
        .length     (length),
        .channel    (channel),
        .remaining  (remaining),
        .hdr_last   (hdr_last)
    );

    assign pay_last = (remaining == 15'd1);
    // Offsets 4/5 -> word 0 ... 10/11 -> word 3; the 2-bit subtract wraps as needed.
    assign sh_sel   = idx_q[2:1] - 2'd2;

    always_comb begin
        state_d     = state_q;
        kind_d      = kind_q;
        idx_d       = idx_q;
        hdr_valid   = 1'b0;
        pay_byte    = 1'b0;
        sh_we       = 1'b0;
        id_known    = 1'b1;
        err_d       = 1'b0;
        commit_rot  = 1'b0;
        commit_gyro = 1'b0;

        if (bus.rx_frame_start) begin
            state_d = StHdr;
        end else begin
            case (state_q)
                StHdr: begin
                    if (bus.rx_valid) begin
                        hdr_valid = 1'b1;
                        if (hdr_last) begin
                            if (length < 15'(ShtpHdrBytes)) begin
                                err_d   = 1'b1;
                                state_d = StDiscard;
                            end else if (length == 15'(ShtpHdrBytes)) begin
                                state_d = StIdle;
                            end else if (channel != SensorChannel) begin
                                state_d = StDiscard;
                            end else begin
                                state_d = StRptId;
                            end
                        end
                    end
                end
                StRptId: begin
                    if (bus.rx_valid) begin
                        pay_byte = 1'b1;
                        idx_d    = 4'd1;
                        if (bus.rx_byte == TsBaseId || bus.rx_byte == TsDeltaId) begin
                            kind_d = RptTs;
                        end else if (bus.rx_byte == RotReportId) begin
                            kind_d = RptRot;
                        end else if (bus.rx_byte == GyroReportId) begin
                            kind_d = RptGyro;
                        end else begin
                            id_known = 1'b0;
                        end
                        // Unknown IDs leave the report length unknown, so the rest is dropped.
                        if (!id_known) begin
                            err_d   = 1'b1;
                            state_d = pay_last ? StIdle : StDiscard;
                        end else if (pay_last) begin
                            err_d   = 1'b1;
                            state_d = StIdle;
                        end else begin
                            state_d = StRptBody;
                        end
                    end
                end
                StRptBody: begin
                    if (bus.rx_valid) begin
                        pay_byte = 1'b1;
                        sh_we    = (kind_q != RptTs);
                        idx_d    = idx_q + 4'd1;
                        if (idx_q == rpt_last_idx(kind_q)) begin
                            commit_rot  = (kind_q == RptRot);
                            commit_gyro = (kind_q == RptGyro);
                            state_d     = pay_last ? StIdle : StRptId;
                        end else if (pay_last) begin
                            err_d   = 1'b1;
                            state_d = StIdle;
                        end
                    end
                end
                StDiscard: begin
                    // remaining is 0 after a bad length: only frame end gets us out.
                    if (bus.rx_valid && remaining != '0) begin
                        pay_byte = 1'b1;
                        if (pay_last) begin
                            state_d = StIdle;
                        end
                    end
                end
                default: ;
            endcase

            // Coincident byte has already been processed above; a report still open is
            // a truncation.
            if (bus.rx_frame_end) begin
                if (state_d == StRptBody) begin
                    err_d = 1'b1;
                end
                state_d = StIdle;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            kind_q       <= RptTs;
            idx_q        <= '0;
            for (int i = 0; i < 4; i++) begin
                sh_q[i] <= '0;
            end
            quat_valid_q <= 1'b0;
            gyro_valid_q <= 1'b0;
            parse_err_q  <= 1'b0;
            quat_w_q     <= '0;
            quat_x_q     <= '0;
            quat_y_q     <= '0;
            quat_z_q     <= '0;
            gyro_x_q     <= '0;
            gyro_y_q     <= '0;
            gyro_z_q     <= '0;
        end else begin
            state_q      <= state_d;
            kind_q       <= kind_d;
            idx_q        <= idx_d;
            quat_valid_q <= commit_rot;
            gyro_valid_q <= commit_gyro;
            parse_err_q  <= err_d;

            if (sh_we && idx_q >= 4'd4) begin
                if (idx_q[0]) begin
                    sh_q[sh_sel][15:8] <= bus.rx_byte;
                end else begin
                    sh_q[sh_sel][7:0]  <= bus.rx_byte;
                end
            end

            // The final report byte is still on rx_byte, so it bypasses the shadow.
            if (commit_rot) begin
                quat_x_q <= sh_q[0];
                quat_y_q <= sh_q[1];
                quat_z_q <= sh_q[2];
                quat_w_q <= {bus.rx_byte, sh_q[3][7:0]};
            end
            if (commit_gyro) begin
                gyro_x_q <= sh_q[0];
                gyro_y_q <= sh_q[1];
                gyro_z_q <= {bus.rx_byte, sh_q[2][7:0]};
            end
        end
    end

    assign bus.quat_valid = quat_valid_q;
    assign bus.quat_w     = quat_w_q;
    assign bus.quat_x     = quat_x_q;
    assign bus.quat_y     = quat_y_q;
    assign bus.quat_z     = quat_z_q;
    assign bus.gyro_valid = gyro_valid_q;
    assign bus.gyro_x     = gyro_x_q;
    assign bus.gyro_y     = gyro_y_q;
    assign bus.gyro_z     = gyro_z_q;
    assign bus.parse_err  = parse_err_q;

endmodule

// File: tb/tb_bno085_report_parser.sv
// Directed bench for bno085_report_parser: hand-built SHTP packets, inline checks.
module tb_bno085_report_parser;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    bno085_report_parser_if bus ();

    bno085_report_parser dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    // Pulse monitor
    int cyc = 0;
    int last_acc = 0;
    int quat_cnt = 0;
    int gyro_cnt = 0;
    int err_cnt = 0;
    int both_cnt = 0;
    int quat_lat = 0;
    int gyro_lat = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.rx_valid) last_acc <= cyc;
    end

    always @(negedge clk) begin
        if (bus.quat_valid) begin
            quat_cnt <= quat_cnt + 1;
            quat_lat <= cyc - last_acc;
        end
        if (bus.gyro_valid) begin
            gyro_cnt <= gyro_cnt + 1;
            gyro_lat <= cyc - last_acc;
        end
        if (bus.quat_valid && bus.gyro_valid) both_cnt <= both_cnt + 1;
        if (bus.parse_err) err_cnt <= err_cnt + 1;
    end

    logic [7:0]  q[$];
    logic [63:0] qv;
    logic [47:0] gv;
    int q0, g0, e0, b0;

    always_comb qv = {bus.quat_w, bus.quat_x, bus.quat_y, bus.quat_z};
    always_comb gv = {bus.gyro_x, bus.gyro_y, bus.gyro_z};

    task automatic send_frame(input logic [7:0] b[$], input bit merge_start,
                              input bit end_frame);
        int first;
        @(negedge clk);
        bus.rx_frame_start = 1'b1;
        if (merge_start) begin
            bus.rx_valid = 1'b1;
            bus.rx_byte  = b[0];
            first = 1;
        end else begin
            bus.rx_valid = 1'b0;
            first = 0;
        end
        for (int i = first; i < b.size(); i++) begin
            @(negedge clk);
            bus.rx_frame_start = 1'b0;
            bus.rx_valid = 1'b1;
            bus.rx_byte  = b[i];
        end
        @(negedge clk);
        bus.rx_frame_start = 1'b0;
        bus.rx_valid = 1'b0;
        if (end_frame) begin
            bus.rx_frame_end = 1'b1;
            @(negedge clk);
            bus.rx_frame_end = 1'b0;
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic snap();
        q0 = quat_cnt;
        g0 = gyro_cnt;
        e0 = err_cnt;
        b0 = both_cnt;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.rx_frame_start = 1'b0;
        bus.rx_frame_end = 1'b0;
        bus.rx_valid = 1'b0;
        bus.rx_byte = 8'h00;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.quat_valid, bus.gyro_valid, bus.parse_err} !== 3'b000) begin
            errors++;
            $display("FAIL reset_pulses: got %b expected 000",
                     {bus.quat_valid, bus.gyro_valid, bus.parse_err});
        end
        checks++;
        if (qv !== 64'h0) begin
            errors++;
            $display("FAIL reset_quat: got %h expected 0", qv);
        end
        checks++;
        if (gv !== 48'h0) begin
            errors++;
            $display("FAIL reset_gyro: got %h expected 0", gv);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_quat();
        snap();
        q = '{8'h15, 8'h00, 8'h03, 8'h00,
              8'hFB, 8'h00, 8'h00, 8'h00, 8'h00,
              8'h08, 8'h01, 8'h00, 8'h00, 8'h00, 8'h40, 8'h00, 8'h00,
              8'h00, 8'h00, 8'h00, 8'h00};
        send_frame(q, 1'b0, 1'b1);
        checks++;
        if (quat_cnt - q0 !== 1) begin
            errors++;
            $display("FAIL quat_count: got %0d expected 1", quat_cnt - q0);
        end
        checks++;
        if (qv !== 64'h0000_4000_0000_0000) begin
            errors++;
            $display("FAIL quat_values: got %h expected 0000400000000000", qv);
        end
        checks++;
        if (quat_lat !== 1) begin
            errors++;
            $display("FAIL quat_latency: got %0d expected 1", quat_lat);
        end
        checks++;
        if (gyro_cnt - g0 !== 0) begin
            errors++;
            $display("FAIL quat_no_gyro: got %0d expected 0", gyro_cnt - g0);
        end
        checks++;
        if (err_cnt - e0 !== 0) begin
            errors++;
            $display("FAIL quat_no_err: got %0d expected 0", err_cnt - e0);
        end
    endtask

    task automatic test_gyro();
        snap();
        // Continuation bit set in lenH must be ignored.
        q = '{8'h0E, 8'h80, 8'h03, 8'h01,
              8'h02, 8'h00, 8'h00, 8'h00, 8'h34, 8'h12, 8'hFE, 8'hFF, 8'h00, 8'h80};
        send_frame(q, 1'b0, 1'b1);
        checks++;
        if (gyro_cnt - g0 !== 1) begin
            errors++;
            $display("FAIL gyro_count: got %0d expected 1", gyro_cnt - g0);
        end
        checks++;
        if (gv !== 48'h1234_FFFE_8000) begin
            errors++;
            $display("FAIL gyro_values: got %h expected 1234fffe8000", gv);
        end
        checks++;
        if (bus.gyro_y !== -16'sd2) begin
            errors++;
            $display("FAIL gyro_y_signed: got %0d expected -2", bus.gyro_y);
        end
        checks++;
        if (gyro_lat !== 1) begin
            errors++;
            $display("FAIL gyro_latency: got %0d expected 1", gyro_lat);
        end
        checks++;
        if (qv !== 64'h0000_4000_0000_0000 || err_cnt - e0 !== 0) begin
            errors++;
            $display("FAIL gyro_quat_hold: got %h errs %0d expected 0000400000000000 errs 0",
                     qv, err_cnt - e0);
        end
    endtask

    task automatic test_back_to_back();
        snap();
        // Frame start coincident with the first (lenL) byte.
        q = '{8'h1F, 8'h00, 8'h03, 8'h02,
              8'hFA, 8'h00, 8'h00, 8'h00, 8'h00,
              8'h08, 8'h02, 8'h00, 8'h00, 8'h01, 8'h00, 8'h02, 8'h00,
              8'h03, 8'h00, 8'hFF, 8'h7F,
              8'h02, 8'h03, 8'h00, 8'h00, 8'h11, 8'h11, 8'h22, 8'h22, 8'h33, 8'h33};
        send_frame(q, 1'b1, 1'b1);
        checks++;
        if (quat_cnt - q0 !== 1 || gyro_cnt - g0 !== 1) begin
            errors++;
            $display("FAIL b2b_counts: got quat %0d gyro %0d expected 1 and 1",
                     quat_cnt - q0, gyro_cnt - g0);
        end
        checks++;
        if (both_cnt - b0 !== 0) begin
            errors++;
            $display("FAIL b2b_overlap: got %0d expected 0", both_cnt - b0);
        end
        checks++;
        if (qv !== 64'h7FFF_0001_0002_0003) begin
            errors++;
            $display("FAIL b2b_quat: got %h expected 7fff000100020003", qv);
        end
        checks++;
        if (gv !== 48'h1111_2222_3333) begin
            errors++;
            $display("FAIL b2b_gyro: got %h expected 111122223333", gv);
        end
        checks++;
        if (err_cnt - e0 !== 0) begin
            errors++;
            $display("FAIL b2b_no_err: got %0d expected 0", err_cnt - e0);
        end
    endtask

    task automatic test_discard();
        snap();
        q = '{8'h10, 8'h00, 8'h02, 8'h00,
              8'h08, 8'h00, 8'h00, 8'h00, 8'hAA, 8'hAA, 8'hBB, 8'hBB,
              8'hCC, 8'hCC, 8'hDD, 8'hDD};
        send_frame(q, 1'b0, 1'b1);
        q = '{8'h04, 8'h00, 8'h03, 8'h00};
        send_frame(q, 1'b0, 1'b1);
        // Stray bytes with no frame open.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus.rx_valid = 1'b1;
            bus.rx_byte = 8'h08;
        end
        @(negedge clk);
        bus.rx_valid = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (quat_cnt - q0 !== 0 || gyro_cnt - g0 !== 0) begin
            errors++;
            $display("FAIL discard_valids: got quat %0d gyro %0d expected 0 and 0",
                     quat_cnt - q0, gyro_cnt - g0);
        end
        checks++;
        if (err_cnt - e0 !== 0) begin
            errors++;
            $display("FAIL discard_no_err: got %0d expected 0", err_cnt - e0);
        end
        checks++;
        if (qv !== 64'h7FFF_0001_0002_0003) begin
            errors++;
            $display("FAIL discard_quat_hold: got %h expected 7fff000100020003", qv);
        end
    endtask

    task automatic test_errors();
        snap();
        q = '{8'h0A, 8'h00, 8'h03, 8'h00, 8'h99, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        send_frame(q, 1'b0, 1'b1);
        checks++;
        if (err_cnt - e0 !== 1) begin
            errors++;
            $display("FAIL err_unknown_id: got %0d expected 1", err_cnt - e0);
        end
        snap();
        q = '{8'h02, 8'h00, 8'h03, 8'h00, 8'hAA, 8'hBB};
        send_frame(q, 1'b0, 1'b1);
        checks++;
        if (err_cnt - e0 !== 1) begin
            errors++;
            $display("FAIL err_short_len: got %0d expected 1", err_cnt - e0);
        end
        snap();
        q = '{8'h08, 8'h00, 8'h03, 8'h00, 8'h08, 8'h01, 8'h00, 8'h00};
        send_frame(q, 1'b0, 1'b1);
        checks++;
        if (err_cnt - e0 !== 1) begin
            errors++;
            $display("FAIL err_cross_payload: got %0d expected 1", err_cnt - e0);
        end
        snap();
        q = '{8'h10, 8'h00, 8'h03, 8'h00, 8'h08, 8'h00, 8'h00, 8'h00, 8'h55, 8'h55};
        send_frame(q, 1'b0, 1'b1);
        checks++;
        if (err_cnt - e0 !== 1) begin
            errors++;
            $display("FAIL err_frame_end: got %0d expected 1", err_cnt - e0);
        end
        checks++;
        if (quat_cnt - q0 !== 0 || gyro_cnt - g0 !== 0) begin
            errors++;
            $display("FAIL err_no_valid: got quat %0d gyro %0d expected 0 and 0",
                     quat_cnt - q0, gyro_cnt - g0);
        end
        checks++;
        if (qv !== 64'h7FFF_0001_0002_0003 || gv !== 48'h1111_2222_3333) begin
            errors++;
            $display("FAIL err_outputs_hold: got %h %h expected 7fff000100020003 111122223333",
                     qv, gv);
        end
    endtask

    task automatic test_reset_mid();
        snap();
        q = '{8'h10, 8'h00, 8'h03, 8'h00, 8'h08, 8'h00, 8'h00, 8'h00, 8'h11, 8'h22};
        send_frame(q, 1'b0, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (qv !== 64'h0 || gv !== 48'h0) begin
            errors++;
            $display("FAIL rstmid_outputs: got %h %h expected 0 0", qv, gv);
        end
        checks++;
        if (err_cnt - e0 !== 0 || quat_cnt - q0 !== 0 || gyro_cnt - g0 !== 0) begin
            errors++;
            $display("FAIL rstmid_pulses: got err %0d quat %0d gyro %0d expected 0 0 0",
                     err_cnt - e0, quat_cnt - q0, gyro_cnt - g0);
        end
        q = '{8'h0E, 8'h00, 8'h03, 8'h00,
              8'h02, 8'h00, 8'h00, 8'h00, 8'hAA, 8'h00, 8'hBB, 8'h00, 8'hCC, 8'h00};
        send_frame(q, 1'b0, 1'b1);
        checks++;
        if (gv !== 48'h00AA_00BB_00CC) begin
            errors++;
            $display("FAIL rstmid_gyro: got %h expected 00aa00bb00cc", gv);
        end
        checks++;
        if (qv !== 64'h0 || gyro_cnt - g0 !== 1) begin
            errors++;
            $display("FAIL rstmid_after: got quat %h gyro pulses %0d expected 0 and 1",
                     qv, gyro_cnt - g0);
        end
    endtask

    initial begin
        test_reset();
        test_quat();
        test_gyro();
        test_back_to_back();
        test_discard();
        test_errors();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
